// File: rtl/coin_hopper_ctrl.sv
// Coin hopper controller: selects the highest requested denomination, pulses its
// solenoid, waits for the coin sensor, and keeps per-denomination stock and a value total.
module coin_hopper_ctrl #(
    parameter int kNumCoins     = 3,
    parameter int kStockBits    = 8,
    parameter int kInitStock    = 10,
    parameter int kFireCycles   = 2,
    parameter int kSenseTimeout = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [kNumCoins-1:0]  i_return_coin,
    input  logic [kNumCoins-1:0]  i_hopper_sense,
    input  logic [kNumCoins-1:0]  i_refill,
    input  logic [kStockBits-1:0] i_refill_count,
    input  logic                  i_clear_fault,
    output logic [kNumCoins-1:0]  o_hopper_fire,
    output logic                  o_return_ack,
    output logic                  o_return_nack,
    output logic [kNumCoins-1:0]  o_empty,
    output logic                  o_fault,
    output logic [30:0]           o_dispensed_total
);

    localparam int kTimerMax = (kFireCycles > kSenseTimeout) ? kFireCycles : kSenseTimeout;
    localparam int kTimerW   = $clog2(kTimerMax + 1);

    typedef logic [kStockBits-1:0] stock_t;

    typedef enum logic [2:0] {
        IDLE,
        FIRE,
        WAIT_SENSE,
        ACK,
        FAULT
    } state_t;

    function automatic logic [30:0] coin_value(input int idx);
        case (idx)
            0:       return 31'd100;
            1:       return 31'd500;
            2:       return 31'd1000;
            default: return 31'd0;
        endcase
    endfunction

    // Sum is at most twice the maximum, so the carry bit alone flags overflow.
    function automatic stock_t sat_stock(input logic [kStockBits:0] v);
        if (v[kStockBits]) begin
            return '1;
        end
        return v[kStockBits-1:0];
    endfunction

    function automatic logic [kNumCoins-1:0] highest_bit(input logic [kNumCoins-1:0] req);
        logic [kNumCoins-1:0] r;
        r = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (req[i]) begin
                r    = '0;
                r[i] = 1'b1;
            end
        end
        return r;
    endfunction

    state_t               state_q, state_d;
    logic [kTimerW-1:0]   timer_q, timer_d;
    logic [kNumCoins-1:0] active_q, active_d;
    logic                 nack_q, nack_d;
    logic [30:0]          total_q, total_d;
    stock_t               stock_q [kNumCoins];
    stock_t               stock_d [kNumCoins];

    logic [kNumCoins-1:0] sel;
    logic [kNumCoins-1:0] empty;
    logic [30:0]          coin_amt;
    logic                 ack;

    always_comb begin
        for (int i = 0; i < kNumCoins; i++) begin
            empty[i] = (stock_q[i] == '0);
        end
    end

    assign sel = highest_bit(i_return_coin);
    assign ack = (state_q == ACK);

    // The cycle after a nack is not re-evaluated so a held request yields pulses.
    always_comb begin
        state_d  = state_q;
        timer_d  = timer_q;
        active_d = active_q;
        nack_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (!nack_q && (i_return_coin != '0)) begin
                    active_d = sel;
                    if ((sel & empty) != '0) begin
                        nack_d = 1'b1;
                    end else begin
                        state_d = FIRE;
                        timer_d = '0;
                    end
                end
            end
            FIRE: begin
                if (timer_q == kTimerW'(kFireCycles - 1)) begin
                    state_d = WAIT_SENSE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_SENSE: begin
                if ((i_hopper_sense & active_q) != '0) begin
                    state_d = ACK;
                    timer_d = '0;
                end else if (timer_q == kTimerW'(kSenseTimeout - 1)) begin
                    state_d = FAULT;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            ACK: begin
                state_d = IDLE;
            end
            FAULT: begin
                if (i_clear_fault) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    // Refill and the ACK decrement are merged before saturating.
    always_comb begin
        coin_amt = '0;
        for (int i = 0; i < kNumCoins; i++) begin
            if (active_q[i]) begin
                coin_amt = coin_amt | coin_value(i);
            end
        end
        total_d = ack ? (total_q + coin_amt) : total_q;
        for (int i = 0; i < kNumCoins; i++) begin
            stock_d[i] = sat_stock({1'b0, stock_q[i]}
                                   + (i_refill[i] ? {1'b0, i_refill_count} : '0)
                                   - {{kStockBits{1'b0}}, (ack && active_q[i])});
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            timer_q  <= '0;
            active_q <= '0;
            nack_q   <= 1'b0;
            total_q  <= '0;
            for (int i = 0; i < kNumCoins; i++) begin
                stock_q[i] <= stock_t'(kInitStock);
            end
        end else begin
            state_q  <= state_d;
            timer_q  <= timer_d;
            active_q <= active_d;
            nack_q   <= nack_d;
            total_q  <= total_d;
            for (int i = 0; i < kNumCoins; i++) begin
                stock_q[i] <= stock_d[i];
            end
        end
    end

    assign o_hopper_fire     = (state_q == FIRE) ? active_q : '0;
    assign o_return_ack      = ack;
    assign o_return_nack     = nack_q;
    assign o_empty           = empty;
    assign o_fault           = (state_q == FAULT);
    assign o_dispensed_total = total_q;

endmodule

// File: tb/tb_coin_hopper_ctrl.sv
// Randomized bench for coin_hopper_ctrl against a transaction-level model of
// stock counts, dispensed value and expected output timing.
module tb_coin_hopper_ctrl;

    localparam int kN    = 3;
    localparam int kSB   = 8;
    localparam int kInit = 10;
    localparam int kFire = 2;
    localparam int kTo   = 16;
    localparam int kMax  = 255;

    logic           clk = 1'b0;
    logic           reset;
    logic [kN-1:0]  ret, sense, refill;
    logic [kSB-1:0] rcount;
    logic           clear;
    logic [kN-1:0]  o_hopper_fire;
    logic           o_return_ack, o_return_nack, o_fault;
    logic [kN-1:0]  o_empty;
    logic [30:0]    o_dispensed_total;

    coin_hopper_ctrl #(
        .kNumCoins(kN), .kStockBits(kSB), .kInitStock(kInit),
        .kFireCycles(kFire), .kSenseTimeout(kTo)
    ) dut (
        .clk(clk), .reset(reset),
        .i_return_coin(ret), .i_hopper_sense(sense), .i_refill(refill),
        .i_refill_count(rcount), .i_clear_fault(clear),
        .o_hopper_fire(o_hopper_fire), .o_return_ack(o_return_ack),
        .o_return_nack(o_return_nack), .o_empty(o_empty), .o_fault(o_fault),
        .o_dispensed_total(o_dispensed_total)
    );

    always #5 clk = ~clk;

    int     n_total = 0;
    int     n_pass  = 0;
    int     m_stock [kN];
    longint m_total;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    function automatic int coin_val(input int i);
        return (i == 2) ? 1000 : (i == 1) ? 500 : 100;
    endfunction

    function automatic int top_bit(input logic [kN-1:0] r);
        for (int i = kN - 1; i >= 0; i--) if (r[i]) return i;
        return -1;
    endfunction

    function automatic int sat(input int v);
        return (v > kMax) ? kMax : v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < kN; i++) m_stock[i] = kInit;
        m_total = 0;
    endtask

    task automatic check_model(input string tag);
        logic [kN-1:0] e;
        for (int i = 0; i < kN; i++) begin
            e[i] = (m_stock[i] == 0);
            check_eq($sformatf("%s stock%0d", tag, i), 32'(dut.stock_q[i]), 32'(m_stock[i]));
        end
        check_eq($sformatf("%s total", tag), {1'b0, o_dispensed_total}, 32'(m_total));
        check_eq($sformatf("%s empty", tag), 32'(o_empty), 32'(e));
    endtask

    task automatic do_reset();
        reset = 1'b1; ret = '0; sense = '0; refill = '0; rcount = '0; clear = 1'b0;
        model_reset();
        tick();
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic idle_refill(input logic [kN-1:0] mask, input int cnt);
        refill = mask;
        rcount = kSB'(cnt);
        for (int i = 0; i < kN; i++) if (mask[i]) m_stock[i] = sat(m_stock[i] + cnt);
        tick();
        refill = '0;
        rcount = '0;
        check_model("refill");
    endtask

    // One request held for one cycle; sense arrives 'delay' cycles into the wait.
    task automatic do_coin(input logic [kN-1:0] req, input int delay, input logic [kN-1:0] ack_mask,
                           input int ack_cnt, input bit noise, input bit reset_mid);
        int            s;
        int            lat;
        logic [kN-1:0] onehot;
        s      = top_bit(req);
        onehot = kN'(1) << s;
        ret    = req;
        tick();
        lat = 1;
        ret = '0;
        if (m_stock[s] == 0) begin
            check_eq("nack pulse", 32'(o_return_nack), 32'd1);
            check_eq("nack fire idle", 32'(o_hopper_fire), 32'd0);
            check_eq("nack empty bit", 32'(o_empty[s]), 32'd1);
            tick();
            check_eq("nack width", 32'(o_return_nack), 32'd0);
            check_eq("nack fire stays 0", 32'(o_hopper_fire), 32'd0);
            return;
        end
        check_eq("no nack", 32'(o_return_nack), 32'd0);
        for (int c = 0; c < kFire; c++) begin
            check_eq($sformatf("fire c%0d", c), 32'(o_hopper_fire), 32'(onehot));
            if (noise) begin
                ret   = kN'($urandom);
                sense = kN'($urandom);
            end
            tick();
            lat++;
        end
        ret   = '0;
        sense = '0;
        check_eq("fire off", 32'(o_hopper_fire), 32'd0);
        for (int w = 0; w < kTo; w++) begin
            if (reset_mid && w == 2) begin
                #2 reset = 1'b1;
                #1;
                model_reset();
                check_eq("rst fire", 32'(o_hopper_fire), 32'd0);
                check_eq("rst ack", 32'(o_return_ack), 32'd0);
                check_eq("rst nack", 32'(o_return_nack), 32'd0);
                check_eq("rst fault", 32'(o_fault), 32'd0);
                check_model("rst");
                sense = '0;
                tick();
                reset = 1'b0;
                tick();
                return;
            end
            sense = (w == delay) ? (onehot | (kN'($urandom) & ~onehot)) : (kN'($urandom) & ~onehot);
            tick();
            lat++;
            if (w == delay) break;
            if (w < kTo - 1) check_eq("wait quiet", {30'd0, o_fault, o_return_ack}, 32'd0);
        end
        sense = '0;
        if (delay >= kTo) begin
            check_eq("fault set", 32'(o_fault), 32'd1);
            check_eq("fault no ack", 32'(o_return_ack), 32'd0);
            check_model("fault");
            ret = 3'b001;
            tick();
            check_eq("fault ignores req", 32'(o_hopper_fire), 32'd0);
            check_eq("fault held", 32'(o_fault), 32'd1);
            ret = '0;
            tick();
            clear = 1'b1;
            tick();
            clear = 1'b0;
            check_eq("fault cleared", 32'(o_fault), 32'd0);
            return;
        end
        check_eq("ack pulse", 32'(o_return_ack), 32'd1);
        check_eq("ack latency", 32'(lat), 32'(kFire + 2 + delay));
        refill = ack_mask;
        rcount = kSB'(ack_cnt);
        for (int i = 0; i < kN; i++)
            m_stock[i] = sat(m_stock[i] + (ack_mask[i] ? ack_cnt : 0) - ((i == s) ? 1 : 0));
        m_total = (m_total + coin_val(s)) % (64'd1 << 31);
        tick();
        refill = '0;
        rcount = '0;
        check_eq("ack width", 32'(o_return_ack), 32'd0);
        check_model("after ack");
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: sim time limit reached, observed 1 expected 0");
        $fatal(1);
    end

    initial begin
        logic [kN-1:0] rq;
        logic [kN-1:0] am;
        int            dl;
        do_reset();
        check_eq("reset fire", 32'(o_hopper_fire), 32'd0);
        check_eq("reset ack", 32'(o_return_ack), 32'd0);
        check_eq("reset nack", 32'(o_return_nack), 32'd0);
        check_eq("reset fault", 32'(o_fault), 32'd0);
        check_model("reset");

        do_coin(3'b001, 0, 3'b000, 0, 1'b0, 1'b0);
        check_eq("single coin stock0", 32'(dut.stock_q[0]), 32'd9);
        check_eq("single coin total", {1'b0, o_dispensed_total}, 32'd100);

        do_coin(3'b110, 0, 3'b000, 0, 1'b0, 1'b0);
        check_eq("multi-hot total", {1'b0, o_dispensed_total}, 32'd1100);

        for (int k = 0; k < kInit; k++) do_coin(3'b010, $urandom_range(0, 5), 3'b000, 0, 1'b1, 1'b0);
        check_eq("drained empty1", 32'(o_empty[1]), 32'd1);
        do_coin(3'b010, 0, 3'b000, 0, 1'b0, 1'b0);

        do_coin(3'b001, kTo, 3'b000, 0, 1'b0, 1'b0);

        do_reset();
        for (int k = 0; k < 5; k++) do_coin(3'b001, 0, 3'b000, 0, 1'b0, 1'b0);
        do_coin(3'b001, 1, 3'b001, 3, 1'b0, 1'b0);
        check_eq("ack+refill net", 32'(dut.stock_q[0]), 32'd7);
        idle_refill(3'b001, 243);
        check_eq("refill to 250", 32'(dut.stock_q[0]), 32'd250);
        idle_refill(3'b001, 10);
        check_eq("refill saturates", 32'(dut.stock_q[0]), 32'd255);
        do_coin(3'b001, 0, 3'b001, 10, 1'b0, 1'b0);
        check_eq("ack+refill at max", 32'(dut.stock_q[0]), 32'd255);

        do_coin(3'b100, 99, 3'b000, 0, 1'b0, 1'b1);

        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 3) == 0) idle_refill(kN'($urandom), $urandom_range(0, 255));
            rq = kN'($urandom_range(1, 7));
            dl = ($urandom_range(0, 7) == 0) ? kTo + 1 : $urandom_range(0, kTo - 1);
            am = ($urandom_range(0, 2) == 0) ? kN'($urandom) : '0;
            do_coin(rq, dl, am, $urandom_range(0, 255), 1'b1, 1'b0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/coin_hopper_ctrl.md
COIN_HOPPER_CTRL -- requirements
Module: coin_hopper_ctrl

Interface
REQ-001 Parameters SHALL be: kNumCoins, default 3, number of denominations; kStockBits, default 8, width of each stock counter; kInitStock, default 10, per-denomination stock after reset; kFireCycles, default 2, solenoid pulse length; kSenseTimeout, default 16, cycles allowed for the sensor to respond; coin values SHALL be fixed at bit0=100, bit1=500, bit2=1000.
REQ-002 Ports SHALL be, in order:
  clk  input  1  single clock; all state changes on its rising edge
  reset  input  1  asynchronous, active-high; clears state immediately
  i_return_coin  input  kNumCoins  level request for one coin; may be one-hot or multi-hot
  i_hopper_sense  input  kNumCoins  coin-passed sensor, one bit per hopper
  i_refill  input  kNumCoins  one-cycle refill strobe per denomination
  i_refill_count  input  kStockBits  coins added by any asserted i_refill bit
  i_clear_fault  input  1  one-cycle strobe clearing FAULT
  o_hopper_fire  output  kNumCoins  solenoid drive, at most one bit high
  o_return_ack  output  1  one-cycle pulse: one coin physically dispensed
  o_return_nack  output  1  one-cycle pulse: request refused, stock empty
  o_empty  output  kNumCoins  bit high while that stock counter is 0
  o_fault  output  1  high while in FAULT
  o_dispensed_total  output  31  running sum of dispensed coin values

Function
REQ-003 FSM states SHALL be IDLE, FIRE, WAIT_SENSE, ACK, FAULT.
REQ-004 In IDLE with i_return_coin nonzero, the block SHALL select the highest set bit (1000 > 500 > 100) and latch it as the active denomination.
REQ-005 If the selected stock is 0, the block SHALL pulse o_return_nack for one cycle on the next clock and remain in IDLE.
REQ-006 If the selected stock is nonzero, the block SHALL enter FIRE on the next clock and drive the latched bit of o_hopper_fire for exactly kFireCycles cycles, then enter WAIT_SENSE.
REQ-007 In WAIT_SENSE, the latched sense bit high SHALL cause transition to ACK on the next clock; sense bits for other denominations SHALL be ignored.
REQ-008 In ACK, for exactly one cycle: o_return_ack SHALL be 1, the latched stock SHALL decrement by 1, and o_dispensed_total SHALL add the coin value; the next state SHALL be IDLE.
REQ-009 Request-to-ack latency with immediate sense SHALL be kFireCycles+2 cycles; a held request SHALL yield one coin per ack, with no back-to-back fire in consecutive cycles.
REQ-010 If sense is still absent after kSenseTimeout cycles in WAIT_SENSE, the FSM SHALL enter FAULT with no decrement and no ack.
REQ-011 FAULT SHALL hold o_fault=1 and o_hopper_fire=0 and ignore requests until i_clear_fault, which returns the FSM to IDLE on the next clock.
REQ-012 Refill SHALL be accepted in every state: stock += i_refill_count for each asserted i_refill bit, saturating at 2^kStockBits-1.
REQ-013 Refill and ACK decrement on the same denomination in the same cycle SHALL net to stock+count-1, saturating at the maximum.
REQ-014 Changes to i_return_coin after latching SHALL NOT affect the coin in progress.
REQ-015 o_dispensed_total SHALL wrap modulo 2^31.
REQ-016 o_empty SHALL be combinational from the stock counters.

Reset
REQ-017 Reset high SHALL immediately force IDLE, o_hopper_fire=0, o_return_ack=0, o_return_nack=0, o_fault=0, o_dispensed_total=0, every stock=kInitStock, and timers=0.
REQ-018 Reset during FIRE or WAIT_SENSE SHALL abort the coin with no decrement and no ack.

Verification
REQ-019 i_return_coin=3'b001 held for 1 cycle, sense asserted the cycle after fire ends -> fire[0] high 2 cycles, ack 4 cycles after the request, stock0=9, total=100.
REQ-020 i_return_coin=3'b110 -> fire[2] only, total=1000 after ack.
REQ-021 Stock1 drained to 0, then request 3'b010 -> nack pulse, o_empty[1]=1, fire stays 0.
REQ-022 Sense withheld -> o_fault=1 after 16 WAIT_SENSE cycles; stock unchanged; i_clear_fault -> IDLE.
REQ-023 Stock0=250, refill0 count=10 -> stock0=255; refill0 count=3 coinciding with an ACK on 100 at stock0=5 -> stock0=7.
REQ-024 Reset asserted mid-WAIT_SENSE -> outputs cleared asynchronously, stocks=10, total=0.
